receive_img: RTL

RECEIVE_IMG -- requirements
Module: receive_img

---
 rtl/receive_img_pkg.sv | 20 ++
 rtl/receive_img_uart_rx.sv | 88 ++++++++
 rtl/receive_img.sv | 81 ++++++++
 3 files changed

// File: rtl/receive_img_pkg.sv
// Shared types and defaults for the UART image receiver.
// Top-level image state encoding is visible on out_state, so its values are fixed.
package receive_img_pkg;

  localparam int DEFAULT_CLOCKS_PER_BAUD = 50;

  typedef enum logic [1:0] {
    IMG_IDLE      = 2'd0,
    IMG_RECEIVING = 2'd1,
    IMG_DONE      = 2'd2
  } img_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/receive_img_uart_rx.sv
// 8N1 UART byte receiver, LSB first, bits sampled mid-cell after a 2-flop synchronizer.
// valid/frame_err pulse one cycle after the stop-bit sample; no backpressure, the consumer must keep up.
module uart_rx
  import receive_img_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BAUD - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rx_sync) state <= RX_START;
        end
        // A start bit that is high again at mid-cell was only a glitch.
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_sync, shreg[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // Returning to idle at mid-stop lets the next start edge be caught immediately.
        RX_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            if (rx_sync) begin
              valid   <= 1'b1;
              rx_data <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/receive_img.sv
// Receives an image byte-stream over UART and writes it sequentially into a BRAM.
// One write cycle after each received byte; no backpressure, the BRAM always accepts.
module receive_img
  import receive_img_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter int NUM_PIXELS      = 16384,
  parameter int ADDR_WIDTH      = 14
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data,
  output logic                  we,
  output logic                  busy,
  output logic                  img_received,
  output logic [7:0]            frame_err_count,
  output logic [1:0]            out_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);

  img_state_t state;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_uart_rx (
    .clk       (clk),
    .rst_in    (rst_in),
    .rx        (rx),
    .rx_data   (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  assign out_state = state;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state           <= IMG_IDLE;
      address         <= '0;
      data            <= '0;
      we              <= 1'b0;
      busy            <= 1'b0;
      img_received    <= 1'b0;
      frame_err_count <= '0;
    end else begin
      we <= 1'b0;

      // Index advances in the cycle after the write it addressed.
      if (we) begin
        if (address == LAST_IDX) begin
          address      <= '0;
          state        <= IMG_DONE;
          busy         <= 1'b0;
          img_received <= 1'b1;
        end else begin
          address <= address + 1'b1;
        end
      end

      if (rx_valid) begin
        we           <= 1'b1;
        data         <= rx_data;
        img_received <= 1'b0;
        if (NUM_PIXELS > 1) begin
          state <= IMG_RECEIVING;
          busy  <= 1'b1;
        end
      end

      if (rx_frame_err && frame_err_count != 8'hFF)
        frame_err_count <= frame_err_count + 1'b1;
    end
  end

endmodule
